maze_nav_controller: RTL

Sequencing controller for the maze renderer. It turns debounced direction-button presses into validated character moves against the 16x16 `path_data` map, and keeps the character inside the scrolled viewport. It drives the renderer's `char_x`/`char_y`/`x_coord`/`y_coord` inputs and commits every change only at a frame boundary, so a frame never shows a torn position. It sits between the button debouncers, the maze generator (`path_data`, sizes, start/goal) and the VGA renderer.

---
 rtl/maze_nav_controller.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/maze_nav_controller.sv
// Purpose : turns debounced button edges into validated maze moves and commits
//           character + viewport position only at frame_start.
// Latency : edge -> CHECK +1 -> PENDING/wall_bump +2 -> commit 1 cycle after frame_start.
// Backpressure: while a move is in flight (move_busy) new button edges are dropped, not queued.
//
// Ports:
//   clk, reset                    clock, async active-high reset
//   btn_up/down/left/right        debounced levels, rising edge requests a move
//   frame_start                   one-cycle pulse at start of vertical blanking
//   load                          reinitialise character to start_x/start_y
//   path_data                     GRIDxGRID map, bit x+GRID*y, 1 = open
//   maze_width/height             maze size in tiles
//   view_w/view_h                 visible window in tiles
//   start_x/y, goal_x/y           start and goal tiles
//   char_x/y, x_coord/y_coord     committed character tile and viewport origin
//   move_busy, wall_bump          move in flight / rejected-move pulse
//   goal_reached                  sticky goal flag
module maze_nav_controller #(
   parameter int GRID = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   btn_up,
   input  logic                   btn_down,
   input  logic                   btn_left,
   input  logic                   btn_right,
   input  logic                   frame_start,
   input  logic                   load,
   input  logic [GRID*GRID-1:0]   path_data,
   input  logic [6:0]             maze_width,
   input  logic [6:0]             maze_height,
   input  logic [4:0]             view_w,
   input  logic [4:0]             view_h,
   input  logic [4:0]             start_x,
   input  logic [4:0]             start_y,
   input  logic [4:0]             goal_x,
   input  logic [4:0]             goal_y,
   output logic [4:0]             char_x,
   output logic [4:0]             char_y,
   output logic [4:0]             x_coord,
   output logic [4:0]             y_coord,
   output logic                   move_busy,
   output logic                   wall_bump,
   output logic                   goal_reached
);

   localparam int         IW     = $clog2(GRID*GRID);
   localparam logic [6:0] GRID_W = 7'(GRID);

   typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, PENDING = 2'd2} state_t;
   typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

   // Scroll rule for one axis: keep t visible with minimal origin movement,
   // then clamp so the window never runs past the maze edge.
   function automatic logic [5:0] view_origin(input logic [5:0] t, input logic [5:0] org,
                                              input logic [5:0] vis, input logic [5:0] eff);
      logic [5:0] n;
      logic [5:0] lim;
      if (t < org)
         n = t;
      else if (t >= org + vis)
         n = t - vis + 6'd1;
      else
         n = org;
      lim = (eff > vis) ? eff - vis : 6'd0;
      return (n > lim) ? lim : n;
   endfunction

   state_t      state, state_nxt;
   dir_t        dir, dir_nxt;
   logic [3:0]  btn_now, btn_prev, req;
   logic [5:0]  eff_w, eff_h;
   logic [5:0]  tx, ty;
   logic        underflow, in_bounds, tile_open;
   logic [IW-1:0] path_idx;
   logic [5:0]  tgt_vx, tgt_vy, load_vx, load_vy;
   logic [4:0]  pend_x, pend_y, pend_vx, pend_vy;
   logic        bump_nxt, latch_tgt, commit;

   assign btn_now = {btn_up, btn_down, btn_left, btn_right};
   assign req     = btn_now & ~btn_prev;

   assign eff_w = (maze_width  > GRID_W) ? GRID_W[5:0] : maze_width[5:0];
   assign eff_h = (maze_height > GRID_W) ? GRID_W[5:0] : maze_height[5:0];

   // Target tile for the latched direction, in 6 bits so +1 at the far edge
   // stays distinguishable from an in-range tile.
   always_comb begin
      tx        = {1'b0, char_x};
      ty        = {1'b0, char_y};
      underflow = 1'b0;
      case (dir)
         DIR_UP: begin
            underflow = (char_y == 5'd0);
            ty        = {1'b0, char_y} - 6'd1;
         end
         DIR_DOWN:  ty = {1'b0, char_y} + 6'd1;
         DIR_LEFT: begin
            underflow = (char_x == 5'd0);
            tx        = {1'b0, char_x} - 6'd1;
         end
         default:   tx = {1'b0, char_x} + 6'd1;
      endcase
      in_bounds = !underflow && (tx < eff_w) && (ty < eff_h);
      path_idx  = IW'(int'(ty) * GRID + int'(tx));
      tile_open = in_bounds && path_data[path_idx];
   end

   assign tgt_vx  = view_origin(tx, {1'b0, x_coord}, {1'b0, view_w}, eff_w);
   assign tgt_vy  = view_origin(ty, {1'b0, y_coord}, {1'b0, view_h}, eff_h);
   assign load_vx = view_origin({1'b0, start_x}, 6'd0, {1'b0, view_w}, eff_w);
   assign load_vy = view_origin({1'b0, start_y}, 6'd0, {1'b0, view_h}, eff_h);

   assign move_busy = (state == CHECK) || (state == PENDING);

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      bump_nxt  = 1'b0;
      latch_tgt = 1'b0;
      commit    = 1'b0;
      if (load) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (!goal_reached && (req != 4'b0000)) begin
                  state_nxt = CHECK;
                  if (req[3])      dir_nxt = DIR_UP;
                  else if (req[2]) dir_nxt = DIR_DOWN;
                  else if (req[1]) dir_nxt = DIR_LEFT;
                  else             dir_nxt = DIR_RIGHT;
               end
            end
            CHECK: begin
               if (tile_open) begin
                  state_nxt = PENDING;
                  latch_tgt = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  bump_nxt  = 1'b1;
               end
            end
            PENDING: begin
               if (frame_start) begin
                  state_nxt = IDLE;
                  commit    = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         dir          <= DIR_UP;
         btn_prev     <= 4'b1111;
         wall_bump    <= 1'b0;
         pend_x       <= 5'd0;
         pend_y       <= 5'd0;
         pend_vx      <= 5'd0;
         pend_vy      <= 5'd0;
         char_x       <= 5'd0;
         char_y       <= 5'd0;
         x_coord      <= 5'd0;
         y_coord      <= 5'd0;
         goal_reached <= 1'b0;
      end else begin
         state     <= state_nxt;
         dir       <= dir_nxt;
         btn_prev  <= btn_now;
         wall_bump <= bump_nxt;
         if (latch_tgt) begin
            pend_x  <= tx[4:0];
            pend_y  <= ty[4:0];
            pend_vx <= tgt_vx[4:0];
            pend_vy <= tgt_vy[4:0];
         end
         if (load) begin
            char_x       <= start_x;
            char_y       <= start_y;
            x_coord      <= load_vx[4:0];
            y_coord      <= load_vy[4:0];
            goal_reached <= 1'b0;
         end else if (commit) begin
            char_x       <= pend_x;
            char_y       <= pend_y;
            x_coord      <= pend_vx;
            y_coord      <= pend_vy;
            goal_reached <= goal_reached | ((pend_x == goal_x) && (pend_y == goal_y));
         end
      end
   end

endmodule
